// File: rtl/pipe_sched.sv
// pipe_sched: stage-3/4/5 class and destination registers for the EV22 core.
// Turns hazard HOLD into a bubble, freezes the pipe during memory-read wait
// states, inserts a single flush cycle after a jump, and runs a stall
// watchdog over consecutive HOLD cycles.
module pipe_sched #(
  parameter int TYPE_W    = 7,
  parameter int SEL_W     = 6,
  parameter int MEM_WAIT  = 2,
  parameter int MAX_STALL = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [TYPE_W-1:0] Type2,
  input  logic [SEL_W-1:0]  SelC2,
  input  logic              hold_in,
  input  logic              mem_rd,
  output logic [TYPE_W-1:0] Type3,
  output logic [TYPE_W-1:0] Type4,
  output logic [TYPE_W-1:0] Type5,
  output logic [SEL_W-1:0]  SelC3,
  output logic [SEL_W-1:0]  SelC4,
  output logic [SEL_W-1:0]  SelC5,
  output logic              en_fetch,
  output logic              flush,
  output logic              MR,
  output logic [7:0]        stall_cnt,
  output logic              stall_err
);

  localparam int         JUMP_BIT  = 6;
  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);
  localparam logic [7:0] STALL_LIM = 8'(MAX_STALL);

  typedef enum logic [1:0] {S_RUN, S_MEMWAIT, S_FLUSH} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_wcnt, w_wcnt_nxt;
  logic [TYPE_W-1:0] r_type3, r_type4, r_type5;
  logic [SEL_W-1:0]  r_sel3, r_sel4, r_sel5;
  logic              r_mr;
  logic [7:0]        r_stall, w_stall_nxt;
  logic              r_err;

  logic              w_adv;
  logic [TYPE_W-1:0] w_type3_in;
  logic [SEL_W-1:0]  w_sel3_in;
  logic              w_en_fetch;
  logic              w_flush;
  logic              w_stall_inc;
  logic              w_stall_clr;

  // Next-state, stage-3 input selection and fetch/flush control.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_adv       = 1'b0;
    w_type3_in  = '0;
    w_sel3_in   = '0;
    w_en_fetch  = 1'b0;
    w_flush     = 1'b0;
    w_stall_inc = 1'b0;
    w_stall_clr = 1'b0;
    case (r_state)
      S_RUN: begin
        if (mem_rd) begin
          // Memory read wins over HOLD; HOLD is looked at again after the wait.
          // A pending HOLD keeps the stall count, a clear cycle resets it.
          w_adv       = 1'b1;
          w_state_nxt = S_MEMWAIT;
          w_wcnt_nxt  = WAIT_INIT;
          w_stall_clr = ~hold_in;
        end else if (hold_in) begin
          // Bubble into stage 3; older stages drain.
          w_adv       = 1'b1;
          w_stall_inc = 1'b1;
        end else begin
          w_adv       = 1'b1;
          w_en_fetch  = 1'b1;
          w_stall_clr = 1'b1;
          if (issue_valid) begin
            w_type3_in = Type2;
            w_sel3_in  = SelC2;
            if (Type2[JUMP_BIT]) w_state_nxt = S_FLUSH;
          end
        end
      end
      S_MEMWAIT: begin
        // Pipe frozen; counter was loaded with MEM_WAIT-1 so the freeze is
        // exactly MEM_WAIT cycles including the one at count zero.
        if (r_wcnt == 3'd0) w_state_nxt = S_RUN;
        else                w_wcnt_nxt  = r_wcnt - 3'd1;
      end
      S_FLUSH: begin
        w_adv       = 1'b1;
        w_en_fetch  = 1'b1;
        w_flush     = 1'b1;
        w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Saturating stall counter next value.
  always_comb begin
    w_stall_nxt = r_stall;
    if (w_stall_clr)                     w_stall_nxt = '0;
    else if (w_stall_inc && r_stall != 8'hFF) w_stall_nxt = r_stall + 8'd1;
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Stage 3/4/5 class and destination shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_type3 <= '0;
      r_type4 <= '0;
      r_type5 <= '0;
      r_sel3  <= '0;
      r_sel4  <= '0;
      r_sel5  <= '0;
    end else if (w_adv) begin
      r_type5 <= r_type4;
      r_type4 <= r_type3;
      r_type3 <= w_type3_in;
      r_sel5  <= r_sel4;
      r_sel4  <= r_sel3;
      r_sel3  <= w_sel3_in;
    end
  end

  // MR mirrors the registered wait state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_mr <= 1'b0;
    else       r_mr <= (w_state_nxt == S_MEMWAIT);
  end

  // Stall counter and sticky watchdog flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
      r_err   <= 1'b0;
    end else begin
      r_stall <= w_stall_nxt;
      if (w_stall_nxt >= STALL_LIM) r_err <= 1'b1;
    end
  end

  assign Type3     = r_type3;
  assign Type4     = r_type4;
  assign Type5     = r_type5;
  assign SelC3     = r_sel3;
  assign SelC4     = r_sel4;
  assign SelC5     = r_sel5;
  assign MR        = r_mr;
  assign stall_cnt = r_stall;
  assign stall_err = r_err;
  // Reset overrides the combinational controls so fetch stays off while held.
  assign en_fetch  = w_en_fetch & ~reset;
  assign flush     = w_flush & ~reset;

endmodule

// File: tb/tb_pipe_sched.sv
// Scoreboard bench for pipe_sched: the driver runs a stage-list model and
// queues the outputs expected mid-cycle; a monitor pops and compares.
module tb_pipe_sched;
  localparam int TW = 7, SW = 6, MW = 2, MS = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic issue_valid = 1'b0;
  logic [TW-1:0] Type2 = '0;
  logic [SW-1:0] SelC2 = '0;
  logic hold_in = 1'b0, mem_rd = 1'b0;
  logic [TW-1:0] Type3, Type4, Type5;
  logic [SW-1:0] SelC3, SelC4, SelC5;
  logic en_fetch, flush, MR, stall_err;
  logic [7:0] stall_cnt;

  pipe_sched #(.TYPE_W(TW), .SEL_W(SW), .MEM_WAIT(MW), .MAX_STALL(MS)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .Type2(Type2),
    .SelC2(SelC2), .hold_in(hold_in), .mem_rd(mem_rd),
    .Type3(Type3), .Type4(Type4), .Type5(Type5),
    .SelC3(SelC3), .SelC4(SelC4), .SelC5(SelC5),
    .en_fetch(en_fetch), .flush(flush), .MR(MR),
    .stall_cnt(stall_cnt), .stall_err(stall_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] t3, t4, t5;
    logic [SW-1:0] s3, s4, s5;
    logic en, fl, mr, err;
    logic [7:0] sc;
  } exp_t;

  exp_t sbq[$];
  int total = 0, bad = 0;

  // Reference model: stage list (index 0 = stage 3), freeze cycles left,
  // flush-pending flag, stall run length, watchdog flag.
  logic [TW-1:0] mt[3];
  logic [SW-1:0] ms[3];
  int frz = 0;
  bit fpend = 0;
  int stall = 0;
  bit err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push_in(input logic [TW-1:0] t, input logic [SW-1:0] s);
    mt[2] = mt[1]; mt[1] = mt[0]; mt[0] = t;
    ms[2] = ms[1]; ms[1] = ms[0]; ms[0] = s;
  endtask

  task automatic cyc(input bit r, input bit iv, input logic [TW-1:0] t,
                     input logic [SW-1:0] s, input bit h, input bit m);
    exp_t e;
    @(negedge clk);
    reset = r; issue_valid = iv; Type2 = t; SelC2 = s; hold_in = h; mem_rd = m;
    if (r) begin
      for (int i = 0; i < 3; i++) begin mt[i] = '0; ms[i] = '0; end
      frz = 0; fpend = 0; stall = 0; err = 0;
    end
    e.t3 = mt[0]; e.t4 = mt[1]; e.t5 = mt[2];
    e.s3 = ms[0]; e.s4 = ms[1]; e.s5 = ms[2];
    e.mr = (frz > 0); e.sc = 8'(stall); e.err = err;
    if (r)             begin e.en = 0; e.fl = 0; end
    else if (frz > 0)  begin e.en = 0; e.fl = 0; end
    else if (fpend)    begin e.en = 1; e.fl = 1; end
    else               begin e.en = !(h || m); e.fl = 0; end
    sbq.push_back(e);
    // Effect of the coming rising edge.
    if (!r) begin
      if (frz > 0) frz--;
      else if (fpend) begin push_in('0, '0); fpend = 0; end
      else if (m) begin push_in('0, '0); frz = MW; if (!h) stall = 0; end
      else if (h) begin
        push_in('0, '0);
        if (stall < 255) stall++;
        if (stall >= MS) err = 1;
      end else begin
        push_in(iv ? t : '0, iv ? s : '0);
        if (iv && t[6]) fpend = 1;
        stall = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, 0, 0);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("Type3", 32'(Type3), 32'(e.t3));
        chk("Type4", 32'(Type4), 32'(e.t4));
        chk("Type5", 32'(Type5), 32'(e.t5));
        chk("SelC3", 32'(SelC3), 32'(e.s3));
        chk("SelC4", 32'(SelC4), 32'(e.s4));
        chk("SelC5", 32'(SelC5), 32'(e.s5));
        chk("en_fetch", 32'(en_fetch), 32'(e.en));
        chk("flush", 32'(flush), 32'(e.fl));
        chk("MR", 32'(MR), 32'(e.mr));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
        chk("stall_err", 32'(stall_err), 32'(e.err));
      end
    end
  end

  initial begin
    logic [TW-1:0] t;
    bit r, h, m, iv;
    for (int i = 0; i < 3; i++) begin mt[i] = '0; ms[i] = '0; end
    cyc(1, 0, '0, '0, 0, 0);
    cyc(1, 0, '0, '0, 0, 0);
    // Streaming: R_write to dest 5, then watch it walk stages 3..5.
    cyc(0, 1, 7'h08, 6'd5, 0, 0);
    idle(4);
    // Two HOLD cycles behind a couple of instructions.
    cyc(0, 1, 7'h02, 6'd1, 0, 0);
    cyc(0, 1, 7'h20, 6'd2, 0, 0);
    cyc(0, 1, 7'h04, 6'd3, 1, 0);
    cyc(0, 1, 7'h04, 6'd3, 1, 0);
    cyc(0, 1, 7'h04, 6'd3, 0, 0);
    idle(2);
    // Memory read wait, with HOLD also raised (mem_rd wins).
    cyc(0, 1, 7'h01, 6'd7, 0, 0);
    cyc(0, 1, 7'h10, 6'd9, 1, 1);
    cyc(0, 1, 7'h10, 6'd9, 1, 1);
    cyc(0, 1, 7'h10, 6'd9, 0, 1);
    cyc(0, 1, 7'h10, 6'd9, 0, 0);
    idle(2);
    // Jump followed by a flush cycle; stimulus during flush is ignored.
    cyc(0, 1, 7'h40, 6'd33, 0, 0);
    cyc(0, 1, 7'h08, 6'd11, 1, 1);
    cyc(0, 1, 7'h08, 6'd11, 0, 0);
    idle(2);
    // Watchdog: long HOLD, with a memory wait in the middle holding the count.
    for (int i = 0; i < 8; i++) cyc(0, 1, 7'h02, 6'd4, 1, 0);
    cyc(0, 1, 7'h02, 6'd4, 1, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 7'h02, 6'd4, 1, 0);
    idle(3);
    // Reset mid-MEMWAIT, then an instruction right after release.
    cyc(0, 1, 7'h08, 6'd6, 0, 0);
    cyc(0, 1, 7'h08, 6'd6, 0, 1);
    cyc(1, 1, 7'h08, 6'd6, 0, 0);
    cyc(0, 1, 7'h20, 6'd12, 0, 0);
    idle(3);
    // Reset mid-FLUSH.
    cyc(0, 1, 7'h40, 6'd1, 0, 0);
    cyc(1, 0, '0, '0, 0, 0);
    idle(2);
    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      r  = ($urandom_range(99) == 0);
      h  = ($urandom_range(4) == 0);
      m  = ($urandom_range(9) == 0);
      iv = ($urandom_range(3) != 0);
      t  = ($urandom_range(7) == 0) ? 7'h40 : 7'(1 << $urandom_range(5));
      if (n >= 600 && n < 700) h = 1;   // long stall run reaching the watchdog
      cyc(r, iv, t, 6'($urandom_range(63)), h, m);
    end
    idle(1);
    @(negedge clk);
    #5;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
